// File: rtl/leiwand_rv32_uart_tx.sv
// Wishbone pipelined UART transmitter: TXDATA/STATUS registers, a byte FIFO and an 8N1 serialiser.
// Read data is zero whenever ack is low so it can be OR-combined with the other data-bus slaves.
`timescale 1ns/1ps

module leiwand_rv32_uart_tx #(
    parameter int MEM_WIDTH  = 32,
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 addr,
    input  logic [MEM_WIDTH-1:0] data_in,
    output logic [MEM_WIDTH-1:0] data_out,
    input  logic                 we,
    input  logic                 stb,
    output logic                 ack,
    input  logic                 cyc,
    output logic                 stall,
    output logic                 tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    typedef struct packed {
        tx_state_t        state;
        logic [CNT_W-1:0] count;
        logic [2:0]       bit_idx;
    } dbg_t;

    // Handshake: a request is taken on any edge where cyc && stb && !stall; ack is
    // raised for exactly the following cycle, with read data valid only while ack=1.
    logic accept;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic busy;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_nxt;
    logic              tx_nxt;
    logic              baud_done;

    logic [MEM_WIDTH-1:0] status_word;

    // Checkers bind to this probe; the upper write-data bits are intentionally ignored.
    dbg_t dbg_probe_unused;
    logic data_hi_unused;

    assign dbg_probe_unused = '{state: state, count: count, bit_idx: bit_idx};
    assign data_hi_unused   = ^data_in[MEM_WIDTH-1:8];

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);

    // A pop in the same cycle never releases stall: only the registered full flag counts.
    assign stall  = cyc && stb && we && !addr && fifo_full;
    assign accept = cyc && stb && !stall;
    assign push   = accept && we && !addr;

    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_full;
        status_word[1]    = fifo_empty;
        status_word[2]    = busy;
        status_word[15:8] = 8'(count);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= 1'b0;
            data_out <= '0;
        end else begin
            ack      <= accept;
            data_out <= (accept && !we && addr) ? status_word : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
        end
    end

    // tx_nxt is the level for the coming cycle, so every state change also sets the line.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    baud_nxt  = '0;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift_reg[0];
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = {1'b0, shift_reg[7:1]};
                        tx_nxt    = shift_reg[1];
                        bit_nxt   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
